// File: rtl/swap_pkg.sv
// Shared types and helpers for the swap sequencer: swap entry layout and unordered pair compare.
package swap_pkg;

    localparam int unsigned REG_W = 2;

    typedef struct packed {
        logic [REG_W-1:0] ra;
        logic [REG_W-1:0] rb;
    } swap_entry_t;

    function automatic logic pair_eq(swap_entry_t a, swap_entry_t b);
        return ((a.ra == b.ra) && (a.rb == b.rb)) || ((a.ra == b.rb) && (a.rb == b.ra));
    endfunction

endpackage

// File: rtl/swap_fifo.sv
// Circular FIFO of pending swaps; exposes head, tail, raw storage and per-entry valid flags.
// Supports tail cancellation for the SWAP_COALESCE_EN build of swap_sequencer.
module swap_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                clear,
    input  logic                                push,
    input  swap_pkg::swap_entry_t               push_entry,
    input  logic                                pop,
    input  logic                                cancel,
    output swap_pkg::swap_entry_t               head,
    output swap_pkg::swap_entry_t               tail,
    output swap_pkg::swap_entry_t [DEPTH-1:0]   entries,
    output logic [DEPTH-1:0]                    valid,
    output logic [$clog2(DEPTH):0]              count,
    output logic                                full,
    output logic                                empty
);
    import swap_pkg::*;

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [AW-1:0] tail_idx;
    swap_entry_t   mem [DEPTH];

    assign count    = wptr - rptr;
    assign full     = (count == PW'(DEPTH));
    assign empty    = (wptr == rptr);
    assign head     = mem[rptr[AW-1:0]];
    assign tail_idx = wptr[AW-1:0] - AW'(1);
    assign tail     = mem[tail_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else if (clear) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (pop)
                rptr <= rptr + PW'(1);
            if (push)
                wptr <= wptr + PW'(1);
            else if (cancel)
                wptr <= wptr - PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear)
            mem[wptr[AW-1:0]] <= push_entry;
    end

    // An entry is live when its distance from the read slot is below the occupancy.
    always_comb begin
        logic [AW-1:0] offs;
        valid   = '0;
        entries = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            offs       = AW'(i) - rptr[AW-1:0];
            valid[i]   = ({1'b0, offs} < count);
            entries[i] = mem[i];
        end
    end

endmodule

// File: rtl/swap_sequencer.sv
// Queues SWAP(ra, rb) from decode and issues one per cycle to the register mapper.
// Optional macro SWAP_COALESCE_EN: a request matching the tail entry cancels it.
module swap_sequencer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned REG_W = swap_pkg::REG_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [REG_W-1:0]            req_ra,
    input  logic [REG_W-1:0]            req_rb,
    input  logic                        flush,
    input  logic                        hold,
    input  logic [REG_W-1:0]            lookup_ra,
    input  logic [REG_W-1:0]            lookup_rb,
    output logic                        lookup_hazard,
    output logic                        map_swap,
    output logic [REG_W-1:0]            map_reg1,
    output logic [REG_W-1:0]            map_reg2,
    output logic [$clog2(DEPTH+1)-1:0]  count,
    output logic                        busy
);
    import swap_pkg::*;

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    swap_entry_t              req;
    swap_entry_t              head;
    swap_entry_t              tail;
    swap_entry_t [DEPTH-1:0]  entries;
    logic [DEPTH-1:0]         valid;
    logic [CW-1:0]            fifo_count;
    logic                     full;
    logic                     empty;
    logic                     issue;
    logic                     coalesce_hit;
    logic                     accept;
    logic                     push;
    logic                     cancel;

    assign req.ra = req_ra;
    assign req.rb = req_rb;

    assign issue = !empty && !hold && !flush;

`ifdef SWAP_COALESCE_EN
    // The tail cannot be cancelled while it is also the head leaving this cycle.
    assign coalesce_hit = !empty && pair_eq(req, tail) && !((fifo_count == CW'(1)) && issue);
`else
    logic unused_tail;
    assign unused_tail  = ^tail;
    assign coalesce_hit = 1'b0;
`endif

    assign req_ready = !reset && !flush && (!full || coalesce_hit);
    assign accept    = req_valid && req_ready && (req_ra != req_rb);
    assign push      = accept && !coalesce_hit;
    assign cancel    = accept && coalesce_hit;

    swap_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .clear      (flush),
        .push       (push),
        .push_entry (req),
        .pop        (issue),
        .cancel     (cancel),
        .head       (head),
        .tail       (tail),
        .entries    (entries),
        .valid      (valid),
        .count      (fifo_count),
        .full       (full),
        .empty      (empty)
    );

    assign map_swap = issue;
    assign map_reg1 = issue ? head.ra : '0;
    assign map_reg2 = issue ? head.rb : '0;
    assign count    = fifo_count;
    assign busy     = !empty;

    always_comb begin
        lookup_hazard = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid[i] && ((entries[i].ra == lookup_ra) || (entries[i].rb == lookup_ra) ||
                             (entries[i].ra == lookup_rb) || (entries[i].rb == lookup_rb)))
                lookup_hazard = 1'b1;
        end
    end

endmodule

// File: tb/tb_swap_sequencer.sv
// Self-checking bench for swap_sequencer: queue-based reference model plus directed literal checks.
module tb_swap_sequencer;

    localparam int DEPTH = 4;
    localparam int REG_W = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [REG_W-1:0] req_ra;
    logic [REG_W-1:0] req_rb;
    logic             flush;
    logic             hold;
    logic [REG_W-1:0] lookup_ra;
    logic [REG_W-1:0] lookup_rb;
    logic             lookup_hazard;
    logic             map_swap;
    logic [REG_W-1:0] map_reg1;
    logic [REG_W-1:0] map_reg2;
    logic [CW-1:0]    count;
    logic             busy;

    swap_sequencer #(
        .DEPTH (DEPTH),
        .REG_W (REG_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_ra        (req_ra),
        .req_rb        (req_rb),
        .flush         (flush),
        .hold          (hold),
        .lookup_ra     (lookup_ra),
        .lookup_rb     (lookup_rb),
        .lookup_hazard (lookup_hazard),
        .map_swap      (map_swap),
        .map_reg1      (map_reg1),
        .map_reg2      (map_reg2),
        .count         (count),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending swaps as a plain queue, oldest first.
    typedef struct {
        int ra;
        int rb;
    } ent_t;

    ent_t q[$];

    function automatic bit same_pair(int a0, int b0, int a1, int b1);
        return (a0 == a1 && b0 == b1) || (a0 == b1 && b0 == a1);
    endfunction

    function automatic bit m_pop();
        return q.size() > 0 && !hold && !flush;
    endfunction

    function automatic bit m_hit();
`ifdef SWAP_COALESCE_EN
        if (q.size() == 0) return 0;
        if (q.size() == 1 && m_pop()) return 0;
        return same_pair(q[q.size()-1].ra, q[q.size()-1].rb, int'(req_ra), int'(req_rb));
`else
        return 0;
`endif
    endfunction

    function automatic bit m_ready();
        return !reset && !flush && (q.size() < DEPTH || m_hit());
    endfunction

    function automatic bit m_hazard();
        foreach (q[i])
            if (q[i].ra == int'(lookup_ra) || q[i].rb == int'(lookup_ra) ||
                q[i].ra == int'(lookup_rb) || q[i].rb == int'(lookup_rb))
                return 1;
        return 0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
        end else if (flush) begin
            q.delete();
        end else begin
            bit pop_now, hit_now, acc_now;
            ent_t e;
            pop_now = m_pop();
            hit_now = m_hit();
            acc_now = req_valid && m_ready() && (req_ra != req_rb);
            if (pop_now) void'(q.pop_front());
            if (acc_now) begin
                if (hit_now) begin
                    void'(q.pop_back());
                end else begin
                    e.ra = int'(req_ra);
                    e.rb = int'(req_rb);
                    q.push_back(e);
                end
            end
        end
    end

    always @(negedge clk) begin
        bit p;
        p = m_pop();
        chk("m_ready",  req_ready, m_ready());
        chk("m_swap",   map_swap, p);
        chk("m_reg1",   map_reg1, p ? q[0].ra : 0);
        chk("m_reg2",   map_reg2, p ? q[0].rb : 0);
        chk("m_count",  count, q.size());
        chk("m_busy",   busy, q.size() != 0);
        chk("m_hazard", lookup_hazard, m_hazard());
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int ra, input int rb);
        req_valid = v;
        req_ra    = REG_W'(ra);
        req_rb    = REG_W'(rb);
    endtask

    // Free-running stream: {valid, ra, rb, hold}
    int stream [10][4] = '{
        '{1, 1, 2, 0}, '{1, 2, 1, 0}, '{1, 0, 3, 0}, '{0, 0, 0, 1}, '{1, 3, 0, 1},
        '{1, 1, 1, 0}, '{1, 2, 3, 0}, '{1, 0, 2, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}
    };

    int exp_order [4][2] = '{'{0, 3}, '{1, 2}, '{2, 3}, '{0, 1}};

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        hold  = 1'b0;
        lookup_ra = '0;
        lookup_rb = '0;
        drive(0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", count, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_swap",  map_swap, 0);
        reset = 1'b0;
        #1;
        chk("rst_ready_after", req_ready, 1);

        // Single push, one-cycle latency
        drive(1, 1, 2);
        #1 chk("t1_ready", req_ready, 1);
        step();
        drive(0, 0, 0);
        #1;
        chk("t1_swap", map_swap, 1);
        chk("t1_reg1", map_reg1, 1);
        chk("t1_reg2", map_reg2, 2);
        step();
        chk("t1_busy", busy, 0);

        // Fill under hold, then drain in order while full blocks a new request
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1, exp_order[i][0], exp_order[i][1]);
            step();
        end
        drive(1, 1, 3);
        #1;
        chk("t2_count_full", count, 4);
        chk("t2_ready_full", req_ready, 0);
        step();
        chk("t2_count_stall", count, 4);
        hold = 1'b0;
        #1 chk("t2_ready_full_pop", req_ready, 0);
        for (int i = 0; i < 4; i++) begin
            if (i == 2) drive(0, 0, 0);
            #1;
            chk("t2_order_swap", map_swap, 1);
            chk("t2_order_reg1", map_reg1, exp_order[i][0]);
            chk("t2_order_reg2", map_reg2, exp_order[i][1]);
            step();
        end
        step();
        chk("t2_drained", count, 0);

        // Hazard lookup against a held entry
        hold = 1'b1;
        drive(1, 0, 3);
        step();
        drive(0, 0, 0);
        lookup_ra = 2'd3;
        lookup_rb = 2'd1;
        #1 chk("t3_hazard_hit", lookup_hazard, 1);
        lookup_ra = 2'd1;
        lookup_rb = 2'd2;
        #1 chk("t3_hazard_miss", lookup_hazard, 0);

        // Flush with a concurrent request
        drive(1, 1, 2);
        step();
        drive(1, 2, 3);
        step();
        chk("t4_count3", count, 3);
        drive(1, 1, 2);
        flush = 1'b1;
        #1;
        chk("t4_ready_flush", req_ready, 0);
        chk("t4_swap_flush",  map_swap, 0);
        step();
        flush = 1'b0;
        drive(0, 0, 0);
        #1;
        chk("t4_count_after", count, 0);
        chk("t4_swap_after",  map_swap, 0);
        hold = 1'b0;

        // Self-swap is accepted and dropped
        drive(1, 2, 2);
        #1 chk("t5_ready", req_ready, 1);
        step();
        drive(0, 0, 0);
        #1;
        chk("t5_count", count, 0);
        chk("t5_swap",  map_swap, 0);
        step();
        chk("t5_swap2", map_swap, 0);

        // Reversed pair onto the tail
        hold = 1'b1;
        drive(1, 1, 3);
        step();
        chk("t6_count1", count, 1);
        drive(1, 3, 1);
        step();
        drive(0, 0, 0);
`ifdef SWAP_COALESCE_EN
        chk("t6_count2", count, 0);
`else
        chk("t6_count2", count, 2);
`endif
        hold = 1'b0;
        repeat (3) step();

        foreach (stream[i]) begin
            drive(stream[i][0][0], stream[i][1], stream[i][2]);
            hold = stream[i][3][0];
            step();
        end
        drive(0, 0, 0);
        hold = 1'b0;
        repeat (6) step();

        // Reset mid-operation drops pending swaps
        hold = 1'b1;
        drive(1, 0, 1);
        step();
        drive(0, 0, 0);
        reset = 1'b1;
        #1 chk("t7_count_reset", count, 0);
        step();
        reset = 1'b0;
        hold  = 1'b0;
        repeat (2) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
